// File: rtl/stopwatch_up_cnt.sv
// BCD MM:SS up-counting stopwatch driving a 4-digit multiplexed display.
// Optional lap display freeze is built when LAP_EN is defined.
module stopwatch_up_cnt #(
    parameter int MAX_MIN = 59
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        scan_tick,
    input  logic        start_stop,
    input  logic        clr,
    input  logic        lap,
    output logic [3:0]  ssd,
    output logic [7:0]  D,
    output logic [14:0] out,
    output logic        running
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [3:0] MAX_M1 = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_M0 = 4'(MAX_MIN % 10);

    state_t      state, state_nx;
    logic [3:0]  s0, s1, m0, m1;
    logic [3:0]  i_s0, i_s1, i_m0, i_m1;
    logic [1:0]  idx;
    logic        zero, adv, at_max;
    logic [15:0] live, shown;
    logic [3:0]  digit;

    assign live = {m1, m0, s1, s0};

    always_comb begin
        i_s0 = s0;
        i_s1 = s1;
        i_m0 = m0;
        i_m1 = m1;
        if (s0 == 4'd9) begin
            i_s0 = 4'd0;
            if (s1 == 4'd5) begin
                i_s1 = 4'd0;
                if (m0 == 4'd9) begin
                    i_m0 = 4'd0;
                    i_m1 = m1 + 4'd1;
                end else begin
                    i_m0 = m0 + 4'd1;
                end
            end else begin
                i_s1 = s1 + 4'd1;
            end
        end else begin
            i_s0 = s0 + 4'd1;
        end
    end

    assign at_max = (i_m1 == MAX_M1) && (i_m0 == MAX_M0) &&
                    (i_s1 == 4'd5) && (i_s0 == 4'd9);
    assign adv = (state == RUN) && tick && !clr;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // clr outranks start_stop and tick; reaching the limit outranks start_stop
    always_comb begin
        state_nx = state;
        zero     = 1'b0;
        unique case (state)
            IDLE: if (!clr && start_stop) state_nx = RUN;
            RUN: begin
                if (clr)                zero = 1'b1;
                else if (tick && at_max) state_nx = DONE;
                else if (start_stop)    state_nx = PAUSE;
            end
            PAUSE: begin
                if (clr) begin
                    zero     = 1'b1;
                    state_nx = IDLE;
                end else if (start_stop) begin
                    state_nx = RUN;
                end
            end
            DONE: begin
                if (clr) begin
                    zero     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || zero) begin
            {m1, m0, s1, s0} <= 16'h0000;
        end else if (adv) begin
            {m1, m0, s1, s0} <= {i_m1, i_m0, i_s1, i_s0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst)            idx <= 2'd0;
        else if (scan_tick) idx <= idx + 2'd1;
    end

`ifdef LAP_EN
    logic        hold;
    logic [15:0] snap;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold <= 1'b0;
            snap <= 16'h0000;
        end else if (zero || (adv && at_max)) begin
            hold <= 1'b0;
        end else if (lap && (state == RUN || state == PAUSE)) begin
            hold <= !hold;
            if (!hold) snap <= live;
        end
    end

    assign shown = hold ? snap : live;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign shown      = live;
`endif

    always_comb begin
        unique case (idx)
            2'd0:    digit = shown[3:0];
            2'd1:    digit = shown[7:4];
            2'd2:    digit = shown[11:8];
            default: digit = shown[15:12];
        endcase
    end

    function automatic logic [7:0] seg(input logic [3:0] v);
        unique case (v)
            4'd0:    seg = 8'b00000011;
            4'd1:    seg = 8'b10011111;
            4'd2:    seg = 8'b00100101;
            4'd3:    seg = 8'b00001101;
            4'd4:    seg = 8'b10011001;
            4'd5:    seg = 8'b01001001;
            4'd6:    seg = 8'b01000001;
            4'd7:    seg = 8'b00011111;
            4'd8:    seg = 8'b00000001;
            4'd9:    seg = 8'b00001001;
            default: seg = 8'b11111110;
        endcase
    endfunction

    // dp lit on the minutes-ones digit marks the MM:SS separator
    assign D       = seg(digit) & ((idx == 2'd2) ? 8'hFE : 8'hFF);
    assign ssd     = ~(4'b0001 << idx);
    assign out     = (state == DONE) ? 15'h7FFF : 15'h0000;
    assign running = (state == RUN);

endmodule

// File: tb/tb_stopwatch_up_cnt.sv
// Randomized bench for stopwatch_up_cnt against a seconds-based model.
// Checks a default (59) and a MAX_MIN=0 instance in lockstep.
module tb_stopwatch_up_cnt;

`ifdef LAP_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif

    typedef struct {
        int secs;
        int st;
        bit hold;
        int snap;
        int idx;
    } mdl_t;

    logic clk, rst, tick, scan_tick, start_stop, clr, lap;
    logic [3:0]  ssd_a, ssd_b;
    logic [7:0]  d_a, d_b;
    logic [14:0] out_a, out_b;
    logic        run_a, run_b;

    int   n_chk = 0;
    int   n_err = 0;
    mdl_t ma, mb;

    stopwatch_up_cnt dut_a (
        .clk(clk), .rst(rst), .tick(tick), .scan_tick(scan_tick),
        .start_stop(start_stop), .clr(clr), .lap(lap),
        .ssd(ssd_a), .D(d_a), .out(out_a), .running(run_a)
    );

    stopwatch_up_cnt #(.MAX_MIN(0)) dut_b (
        .clk(clk), .rst(rst), .tick(tick), .scan_tick(scan_tick),
        .start_stop(start_stop), .clr(clr), .lap(lap),
        .ssd(ssd_b), .D(d_b), .out(out_b), .running(run_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // st: 0 idle, 1 run, 2 pause, 3 done
    function automatic mdl_t step(mdl_t m, int mx, bit r, bit t,
                                  bit ss, bit c, bit l, bit sc);
        mdl_t n = m;
        if (r) begin
            n = '{0, 0, 1'b0, 0, 0};
            return n;
        end
        if (sc) n.idx = (m.idx + 1) % 4;
        case (m.st)
            0: if (!c && ss) n.st = 1;
            1: begin
                if (c) begin
                    n.secs = 0;
                    n.hold = 1'b0;
                end else begin
                    if (LAP && l) begin
                        if (!m.hold) n.snap = m.secs;
                        n.hold = !m.hold;
                    end
                    if (t) n.secs = m.secs + 1;
                    if (t && n.secs == mx * 60 + 59) begin
                        n.st   = 3;
                        n.hold = 1'b0;
                    end else if (ss) begin
                        n.st = 2;
                    end
                end
            end
            2: begin
                if (c) begin
                    n.st   = 0;
                    n.secs = 0;
                    n.hold = 1'b0;
                end else begin
                    if (ss) n.st = 1;
                    if (LAP && l) begin
                        if (!m.hold) n.snap = m.secs;
                        n.hold = !m.hold;
                    end
                end
            end
            default: begin
                if (c) begin
                    n.st   = 0;
                    n.secs = 0;
                end
            end
        endcase
        return n;
    endfunction

    function automatic logic [7:0] exp_d(mdl_t m);
        logic [7:0] tab [10];
        int v, dg;
        tab = '{8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101,
                8'b10011001, 8'b01001001, 8'b01000001, 8'b00011111,
                8'b00000001, 8'b00001001};
        v = m.hold ? m.snap : m.secs;
        case (m.idx)
            0:       dg = (v % 60) % 10;
            1:       dg = (v % 60) / 10;
            2:       dg = (v / 60) % 10;
            default: dg = (v / 60) / 10;
        endcase
        return (m.idx == 2) ? (tab[dg] & 8'hFE) : tab[dg];
    endfunction

    function automatic logic [3:0] exp_ssd(mdl_t m);
        logic [3:0] tab [4];
        tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        return tab[m.idx];
    endfunction

    task automatic compare();
        chk("a_ssd", 32'(ssd_a), 32'(exp_ssd(ma)));
        chk("a_D",   32'(d_a),   32'(exp_d(ma)));
        chk("a_out", 32'(out_a), (ma.st == 3) ? 32'h7FFF : 32'h0);
        chk("a_run", 32'(run_a), 32'(ma.st == 1));
        chk("b_ssd", 32'(ssd_b), 32'(exp_ssd(mb)));
        chk("b_D",   32'(d_b),   32'(exp_d(mb)));
        chk("b_out", 32'(out_b), (mb.st == 3) ? 32'h7FFF : 32'h0);
        chk("b_run", 32'(run_b), 32'(mb.st == 1));
    endtask

    task automatic cyc(input bit r, input bit t, input bit ss,
                       input bit c, input bit l, input bit sc);
        rst        = r;
        tick       = t;
        start_stop = ss;
        clr        = c;
        lap        = l;
        scan_tick  = sc;
        @(posedge clk);
        ma = step(ma, 59, r, t, ss, c, l, sc);
        mb = step(mb, 0, r, t, ss, c, l, sc);
        #1;
        compare();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0, 0);
    endtask

    task automatic scan4();
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        ma = '{0, 0, 1'b0, 0, 0};
        mb = ma;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("rst_ssd", 32'(ssd_a), 32'b1110);
        chk("rst_D",   32'(d_a),   32'b00000011);
        chk("rst_out", 32'(out_a), 32'h0);
        chk("rst_run", 32'(run_a), 32'h0);
        scan4();

        cyc(0, 0, 1, 0, 0, 0);
        ticks(61);
        chk("run_61", 32'(run_a), 32'h1);
        chk("done_b", 32'(out_b), 32'h7FFF);
        scan4();
        cyc(0, 0, 1, 0, 0, 0);
        ticks(5);
        chk("paused", 32'(run_a), 32'h0);
        chk("done_hold", 32'(out_b), 32'h7FFF);
        scan4();
        cyc(0, 0, 0, 1, 0, 0);
        chk("clr_b", 32'(out_b), 32'h0);
        scan4();

        cyc(0, 0, 1, 0, 0, 0);
        ticks(3);
        cyc(0, 1, 1, 0, 0, 0);
        chk("ss_tick", 32'(run_a), 32'h0);
        scan4();
        cyc(0, 0, 1, 1, 0, 0);
        chk("clr_ss", 32'(run_a), 32'h0);
        scan4();

        cyc(0, 0, 1, 0, 0, 0);
        ticks(10);
        cyc(0, 0, 0, 0, 1, 0);
        ticks(5);
        scan4();
        cyc(0, 0, 0, 0, 1, 0);
        scan4();

        ticks(192);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("rst_mid", 32'(run_a), 32'h0);
        scan4();

        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 999) == 0,
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 99) == 0,
                $urandom_range(0, 14) == 0,
                $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
